jt89_regs: RTL and testbench
============================

// Module: jt89_regs
// PURPOSE
//  Host-side write decoder and register file for the JT89 PSG. Accepts byte writes in
//  SN76489 latch/data format, holds the 3 tone periods, 4 attenuations and noise control,
//  and drives them to the tone/noise generator instances. Models the chip READY (busy)
//  handshake so CPU cores see original write timing.
// PARAMETERS
//  BUSY_CYCLES  32  clk_en ticks READY stays low after an accepted write (1..255)
// PORTS
//  clk        in   1   system clock; all state on rising edge
//  rst        in   1   asynchronous, active-high reset
//  clk_en     in   1   PSG clock enable; only gates the busy counter
//  cs_n       in   1   chip select, active low
//  wr_n       in   1   write strobe, active low
//  din        in   8   host data byte
//  ready      out  1   1 = can accept a write; 0 = busy
//  tone0      out  10  channel 0 period (to tone generator)
//  tone1      out  10  channel 1 period
//  tone2      out  10  channel 2 period
//  vol0       out  4   channel 0 attenuation (0 = loudest, 15 = off)
//  vol1       out  4   channel 1 attenuation
//  vol2       out  4   channel 2 attenuation
//  vol3       out  4   noise attenuation
//  ctrl3      out  3   noise control {fb, rate[1:0]}
//  noise_rst  out  1   one-clk pulse: noise LFSR must be reloaded
// BEHAVIOUR
//  Reset (async): tone0..2 = 0, vol0..3 = 4'hF, ctrl3 = 0, noise_rst = 0, ready = 1,
//   latched reg = {ch 0, tone}, busy counter = 0, write-detect history = inactive.
//  Write detect: wr_act = ~cs_n & ~wr_n, sampled every clk (not clk_en). Write accepted on
//   the clk edge where wr_act = 1, previous sample = 0 and ready = 1. A strobe held low
//   counts once. A strobe whose leading edge arrives while ready = 0 is dropped entirely,
//   even if still low when ready returns.
//  Latency: register outputs update on the same edge that accepts the write (outputs valid
//   the cycle after the strobe is sampled low). noise_rst is high for exactly that one cycle.
//  Latch byte (din[7] = 1): ch = din[6:5], typ = din[4]; stored as the latched reg.
//   - typ = 1: vol[ch] <= din[3:0].
//   - typ = 0, ch < 3: tone[ch][3:0] <= din[3:0]; tone[ch][9:4] unchanged.
//   - typ = 0, ch = 3: ctrl3 <= din[2:0]; noise_rst pulses.
//  Data byte (din[7] = 0): applied to the latched reg, latch unchanged.
//   - tone ch < 3: tone[ch][9:4] <= din[5:0]; tone[ch][3:0] unchanged.
//   - volume: vol[ch] <= din[3:0]; din[6:4] ignored.
//   - noise ctrl: ctrl3 <= din[2:0]; noise_rst pulses.
//  Repeated data bytes keep hitting the same latched reg.
//  Busy: on accept, ready <= 0 and counter <= BUSY_CYCLES.
//   - Counter decrements only on clk_en cycles.
//   - ready <= 1 on the edge where a clk_en tick takes the counter from 1 to 0.
//   - With clk_en stuck low, ready stays 0.
//  Simultaneous accept and clk_en: the accept load wins; there is no decrement that cycle.
//  Reset mid-busy: ready returns to 1 immediately; a write in progress is lost.
//  Tone value 0 is legal and passed through; interpreting it is the generator's job.
// TESTING
//  1. Reset -> ready=1, all tones 0, vol0..3=15, ctrl3=0, noise_rst=0.
//  2. Write 0x8E then 0x0F to ch0 -> tone0=0x0FE; tone1/2 untouched; ready low 32 clk_en
//     ticks after each byte.
//  3. Write 0xD5 -> vol2=5; then data 0x03 -> vol2=3, tone2 unchanged (latch=vol2).
//  4. Write 0xE6 -> ctrl3=3'b110, noise_rst high exactly 1 clk; then data 0x01 ->
//     ctrl3=3'b001, second pulse.
//  5. Second strobe while ready=0 (clk_en every 4 clk) -> ignored, registers unchanged;
//     ready rises 128 clk after accept.
//  6. Assert rst while busy after 0x8E -> all outputs back to reset values, ready=1
//     asynchronously; next 0x05 data byte -> tone0[9:4]=5 (latch reset to ch0 tone).

Source files
------------

// File: rtl/jt89_regs_if.sv
// Host write bus of the JT89 register file: chip select, write strobe, data byte
// and the READY (not busy) handshake back to the CPU.
interface jt89_regs_if;
  logic       cs_n;
  logic       wr_n;
  logic [7:0] din;
  logic       ready;

  modport master (
    output cs_n,
    output wr_n,
    output din,
    input  ready
  );

  modport slave (
    input  cs_n,
    input  wr_n,
    input  din,
    output ready
  );
endinterface

// File: rtl/jt89_regs.sv
// SN76489-style latch/data write decoder and register file for the JT89 PSG,
// including the READY busy window that mimics the original chip's write timing.
module jt89_regs #(
  parameter int unsigned BUSY_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  jt89_regs_if.slave  bus,
  output logic [9:0]  tone0,
  output logic [9:0]  tone1,
  output logic [9:0]  tone2,
  output logic [3:0]  vol0,
  output logic [3:0]  vol1,
  output logic [3:0]  vol2,
  output logic [3:0]  vol3,
  output logic [2:0]  ctrl3,
  output logic        noise_rst
);

  localparam logic [7:0] BusyLoad = 8'(BUSY_CYCLES);

  logic       wr_act;
  logic       wr_last_q;
  logic       accept;

  // Latched register: {channel[1:0], type}; type 1 = attenuation, 0 = tone/noise ctrl.
  logic [2:0] latch_q, latch_d;
  logic [9:0] tone_q [3];
  logic [9:0] tone_d [3];
  logic [3:0] vol_q [4];
  logic [3:0] vol_d [4];
  logic [2:0] ctrl3_q, ctrl3_d;
  logic       noise_rst_q, noise_rst_d;
  logic       ready_q, ready_d;
  logic [7:0] cnt_q, cnt_d;

  logic       is_latch;
  logic [1:0] sel_ch;
  logic       sel_typ;

  assign wr_act = ~bus.cs_n & ~bus.wr_n;
  // Leading-edge detect: a strobe that starts while busy never produces an edge later.
  assign accept = wr_act & ~wr_last_q & ready_q;

  assign is_latch = bus.din[7];
  assign sel_ch   = is_latch ? bus.din[6:5] : latch_q[2:1];
  assign sel_typ  = is_latch ? bus.din[4]   : latch_q[0];

  always_comb begin
    latch_d     = latch_q;
    ctrl3_d     = ctrl3_q;
    noise_rst_d = 1'b0;
    for (int i = 0; i < 3; i++) tone_d[i] = tone_q[i];
    for (int i = 0; i < 4; i++) vol_d[i] = vol_q[i];

    if (accept) begin
      if (is_latch) latch_d = bus.din[6:4];

      if (sel_typ) begin
        for (int i = 0; i < 4; i++) begin
          if (sel_ch == 2'(i)) vol_d[i] = bus.din[3:0];
        end
      end else if (sel_ch == 2'd3) begin
        ctrl3_d     = bus.din[2:0];
        noise_rst_d = 1'b1;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (sel_ch == 2'(i)) begin
            if (is_latch) tone_d[i][3:0] = bus.din[3:0];
            else          tone_d[i][9:4] = bus.din[5:0];
          end
        end
      end
    end
  end

  // Accept load has priority over a coincident clk_en decrement.
  always_comb begin
    ready_d = ready_q;
    cnt_d   = cnt_q;
    if (accept) begin
      ready_d = 1'b0;
      cnt_d   = BusyLoad;
    end else if (clk_en && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
      if (cnt_q == 8'd1) ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_last_q   <= 1'b0;
      latch_q     <= 3'b000;
      ctrl3_q     <= 3'b000;
      noise_rst_q <= 1'b0;
      ready_q     <= 1'b1;
      cnt_q       <= 8'd0;
      for (int i = 0; i < 3; i++) tone_q[i] <= 10'd0;
      for (int i = 0; i < 4; i++) vol_q[i] <= 4'hF;
    end else begin
      wr_last_q   <= wr_act;
      latch_q     <= latch_d;
      ctrl3_q     <= ctrl3_d;
      noise_rst_q <= noise_rst_d;
      ready_q     <= ready_d;
      cnt_q       <= cnt_d;
      for (int i = 0; i < 3; i++) tone_q[i] <= tone_d[i];
      for (int i = 0; i < 4; i++) vol_q[i] <= vol_d[i];
    end
  end

  assign bus.ready = ready_q;
  assign tone0     = tone_q[0];
  assign tone1     = tone_q[1];
  assign tone2     = tone_q[2];
  assign vol0      = vol_q[0];
  assign vol1      = vol_q[1];
  assign vol2      = vol_q[2];
  assign vol3      = vol_q[3];
  assign ctrl3     = ctrl3_q;
  assign noise_rst = noise_rst_q;

endmodule

// File: tb/tb_jt89_regs.sv
// Directed self-checking bench for jt89_regs: latch/data decoding, noise reload pulse,
// READY busy timing and asynchronous reset.
module tb_jt89_regs;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b1;
  logic [9:0] tone0, tone1, tone2;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [2:0] ctrl3;
  logic       noise_rst;

  int en_mode = 0;  // 0: clk_en every clk, 1: every 4th clk
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int n;

  jt89_regs_if bus ();

  jt89_regs #(.BUSY_CYCLES(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .bus       (bus),
    .tone0     (tone0),
    .tone1     (tone1),
    .tone2     (tone2),
    .vol0      (vol0),
    .vol1      (vol1),
    .vol2      (vol2),
    .vol3      (vol3),
    .ctrl3     (ctrl3),
    .noise_rst (noise_rst)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    clk_en = (en_mode == 0) ? 1'b1 : ((cyc % 4) == 0);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a strobe low with a data byte; returns #1 after the first rising edge.
  task automatic strobe(input logic [7:0] d);
    @(negedge clk);
    bus.cs_n = 1'b0;
    bus.wr_n = 1'b0;
    bus.din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic release_bus();
    @(negedge clk);
    bus.cs_n = 1'b1;
    bus.wr_n = 1'b1;
  endtask

  // Count rising edges until ready is seen high, bounded.
  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (bus.ready !== 1'b1 && cycles < 1000) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic write_byte(input logic [7:0] d, input int exp_busy, input string tag);
    int c;
    strobe(d);
    check({tag, " ready low"}, 16'(bus.ready), 16'd0);
    release_bus();
    @(posedge clk);
    #1;
    wait_ready(c);
    check({tag, " busy len"}, 16'(c + 1), 16'(exp_busy));
  endtask

  initial begin
    bus.cs_n = 1'b1;
    bus.wr_n = 1'b1;
    bus.din  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", 16'(bus.ready), 16'd1);
    check("rst tone0", 16'(tone0), 16'h000);
    check("rst vol3", 16'(vol3), 16'hF);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("ready", 16'(bus.ready), 16'd1);
    check("tone0", 16'(tone0), 16'h000);
    check("tone1", 16'(tone1), 16'h000);
    check("tone2", 16'(tone2), 16'h000);
    check("vol0", 16'(vol0), 16'hF);
    check("vol1", 16'(vol1), 16'hF);
    check("vol2", 16'(vol2), 16'hF);
    check("vol3", 16'(vol3), 16'hF);
    check("ctrl3", 16'(ctrl3), 16'h0);
    check("noise_rst", 16'(noise_rst), 16'h0);

    // Tone ch0 latch + data; busy spans 32 clk_en ticks
    write_byte(8'h8E, 32, "w8E");
    check("tone0 after 8E", 16'(tone0), 16'h00E);
    write_byte(8'h0F, 32, "w0F");
    check("tone0 after 0F", 16'(tone0), 16'h0FE);
    check("tone1 untouched", 16'(tone1), 16'h000);
    check("tone2 untouched", 16'(tone2), 16'h000);

    // Volume latch then data to the same latched reg
    write_byte(8'hD5, 32, "wD5");
    check("vol2 after D5", 16'(vol2), 16'h5);
    write_byte(8'h03, 32, "w03");
    check("vol2 after 03", 16'(vol2), 16'h3);
    check("tone2 after 03", 16'(tone2), 16'h000);
    check("tone0 after 03", 16'(tone0), 16'h0FE);

    // Noise control and one-clk reload pulse
    strobe(8'hE6);
    check("ctrl3 after E6", 16'(ctrl3), 16'h6);
    check("noise_rst pulse", 16'(noise_rst), 16'h1);
    @(posedge clk);
    #1;
    check("noise_rst drop", 16'(noise_rst), 16'h0);
    release_bus();
    wait_ready(n);
    strobe(8'h01);
    check("ctrl3 after 01", 16'(ctrl3), 16'h1);
    check("noise_rst pulse2", 16'(noise_rst), 16'h1);
    @(posedge clk);
    #1;
    check("noise_rst drop2", 16'(noise_rst), 16'h0);
    release_bus();
    wait_ready(n);
    check("vol3 kept", 16'(vol3), 16'hF);

    // Busy window with clk_en every 4 clk; accept coincides with a tick
    en_mode = 1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (clk_en !== 1'b1 && n < 20);
    repeat (3) @(posedge clk);
    strobe(8'h81);
    check("clk_en at accept", 16'(clk_en), 16'h1);
    check("tone0 after 81", 16'(tone0), 16'h0F1);
    release_bus();
    n = 0;
    while (bus.ready !== 1'b1 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 10) begin
        bus.din  = 8'h0A;
        bus.cs_n = 1'b0;
        bus.wr_n = 1'b0;
      end
    end
    check("slow busy len", 16'(n), 16'd128);
    check("dropped strobe tone0", 16'(tone0), 16'h0F1);
    repeat (3) @(posedge clk);
    #1;
    check("held strobe not taken", 16'(bus.ready), 16'd1);
    check("held strobe tone0", 16'(tone0), 16'h0F1);
    release_bus();

    // Async reset while busy
    en_mode = 0;
    @(posedge clk);
    strobe(8'h8E);
    check("tone0 before rst", 16'(tone0), 16'h0FE);
    release_bus();
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async ready", 16'(bus.ready), 16'd1);
    check("async tone0", 16'(tone0), 16'h000);
    check("async vol2", 16'(vol2), 16'hF);
    check("async ctrl3", 16'(ctrl3), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    strobe(8'h05);
    check("tone0 after rst data", 16'(tone0), 16'h050);
    check("vol0 after rst data", 16'(vol0), 16'hF);
    release_bus();
    wait_ready(n);
    check("final ready", 16'(bus.ready), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
